// File: rtl/c_clock_pkg.sv
// c_clock_pkg: state encoding and BCD digit limits shared by the clock counters and display mux.
package c_clock_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] SEC_G_MAX = 4'd5;
  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] m);
    return d > m ? m : d;
  endfunction
endpackage

// File: rtl/c_bcd_down_digit.sv
// c_bcd_down_digit: one BCD digit of a borrow chain; wraps 0 to max and borrows from the next digit.
module c_bcd_down_digit (
  input  logic [3:0] digit,
  input  logic [3:0] max,
  input  logic       borrow_in,
  output logic [3:0] next,
  output logic       borrow_out
);
  assign borrow_out = borrow_in && digit == 4'd0;
  assign next = !borrow_in ? digit : borrow_out ? max : digit - 4'd1;
endmodule

// File: rtl/c_countdown.sv
// c_countdown: BCD MM:SS countdown timer with pause/resume and an auto-clearing alarm.
module c_countdown
  import c_clock_pkg::*;
#(
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_min_g,
  input  logic [3:0] load_min_d,
  input  logic [3:0] load_sec_g,
  input  logic [3:0] load_sec_d,
  input  logic       start,
  input  logic       pause,
  input  logic       ack,
  output logic [3:0] min_g,
  output logic [3:0] min_d,
  output logic [3:0] sec_g,
  output logic [3:0] sec_d,
  output logic       borrow_s,
  output logic       running,
  output logic       done
);
  state_t     r_state;
  logic [7:0] r_alarm;
  logic       r_borrow;
  logic [3:0] r_mg, r_md, r_sg, r_sd;
  logic [3:0] w_mg, w_md, w_sg, w_sd;
  logic       w_bsd, w_bsg, w_bmd, w_bmg;
  logic       w_go, w_nonzero, w_next_zero, w_alarm_end;

  c_bcd_down_digit u_sd (.digit(r_sd), .max(DIGIT_MAX), .borrow_in(1'b1), .next(w_sd), .borrow_out(w_bsd));
  c_bcd_down_digit u_sg (.digit(r_sg), .max(SEC_G_MAX), .borrow_in(w_bsd), .next(w_sg), .borrow_out(w_bsg));
  c_bcd_down_digit u_md (.digit(r_md), .max(DIGIT_MAX), .borrow_in(w_bsg), .next(w_md), .borrow_out(w_bmd));
  c_bcd_down_digit u_mg (.digit(r_mg), .max(DIGIT_MAX), .borrow_in(w_bmd), .next(w_mg), .borrow_out(w_bmg));

  // start together with pause counts as pause
  assign w_go        = start && !pause;
  assign w_nonzero   = |{r_mg, r_md, r_sg, r_sd};
  assign w_next_zero = ~|{w_mg, w_md, w_sg, w_sd};
  assign w_alarm_end = r_alarm == 8'(ALARM_TICKS - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_alarm  <= 8'd0;
      r_borrow <= 1'b0;
      {r_mg, r_md, r_sg, r_sd} <= 16'h0000;
    end else begin
      r_borrow <= 1'b0;
      if (load) begin
        r_state <= S_IDLE;
        r_alarm <= 8'd0;
        r_mg    <= clamp(load_min_g, DIGIT_MAX);
        r_md    <= clamp(load_min_d, DIGIT_MAX);
        r_sg    <= clamp(load_sec_g, SEC_G_MAX);
        r_sd    <= clamp(load_sec_d, DIGIT_MAX);
      end else begin
        case (r_state)
          S_IDLE:  if (w_go && w_nonzero) r_state <= S_RUN;
          S_RUN: begin
            if (pause) r_state <= S_PAUSE;
            else if (tick && !w_bmg) begin
              {r_mg, r_md, r_sg, r_sd} <= {w_mg, w_md, w_sg, w_sd};
              r_borrow <= w_bsg;
              if (w_next_zero) begin
                r_state <= S_DONE;
                r_alarm <= 8'd0;
              end
            end
          end
          S_PAUSE: if (w_go) r_state <= S_RUN;
          S_DONE: begin
            if (ack || (tick && w_alarm_end)) r_state <= S_IDLE;
            else if (tick) r_alarm <= r_alarm + 8'd1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign {min_g, min_d, sec_g, sec_d} = {r_mg, r_md, r_sg, r_sd};
  assign borrow_s = r_borrow;
  assign running  = r_state == S_RUN;
  assign done     = r_state == S_DONE;
endmodule

// File: tb/tb_c_countdown.sv
// tb_c_countdown: directed scoreboard bench for the BCD countdown timer.
module tb_c_countdown;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, ack = 1'b0;
  logic [3:0] load_min_g = 4'd0, load_min_d = 4'd0, load_sec_g = 4'd0, load_sec_d = 4'd0;
  logic [3:0] min_g, min_d, sec_g, sec_d;
  logic borrow_s, running, done;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic [15:0] v;
    logic        b, r, d;
  } obs_t;
  obs_t  exp_q[$];
  string tag_q[$];

  c_countdown #(.ALARM_TICKS(3)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .load_min_g(load_min_g), .load_min_d(load_min_d), .load_sec_g(load_sec_g), .load_sec_d(load_sec_d),
    .start(start), .pause(pause), .ack(ack),
    .min_g(min_g), .min_d(min_d), .sec_g(sec_g), .sec_d(sec_d),
    .borrow_s(borrow_s), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(input logic [15:0] v, input logic b, input logic r, input logic d);
    return '{v: v, b: b, r: r, d: d};
  endfunction

  task automatic preset(input logic [3:0] mg, input logic [3:0] md, input logic [3:0] sg, input logic [3:0] sd);
    {load_min_g, load_min_d, load_sec_g, load_sec_d} = {mg, md, sg, sd};
  endtask

  // ctl = {tick, load, start, pause, ack}
  task automatic step(input logic [4:0] ctl, input string tag, input obs_t e);
    obs_t got, want;
    string t;
    {tick, load, start, pause, ack} = ctl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    {tick, load, start, pause, ack} = 5'b0;
    got  = mk({min_g, min_d, sec_g, sec_d}, borrow_s, running, done);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got v=%h b=%b r=%b d=%b exp v=%h b=%b r=%b d=%b",
             t, got.v, got.b, got.r, got.d, want.v, want.b, want.r, want.d);
    end
  endtask

  localparam logic [4:0] N = 5'b00000, T = 5'b10000, L = 5'b01000, S = 5'b00100, P = 5'b00010, A = 5'b00001;

  initial begin
    step(N, "reset", mk(16'h0000, 0, 0, 0));
    reset = 1'b0;
    preset(0, 1, 0, 0);
    step(L, "load_0100", mk(16'h0100, 0, 0, 0));
    step(S, "start_0100", mk(16'h0100, 0, 1, 0));
    step(T, "tick_0059", mk(16'h0059, 1, 1, 0));
    step(N, "borrow_one_cycle", mk(16'h0059, 0, 1, 0));
    preset(0, 0, 0, 2);
    step(L, "load_0002", mk(16'h0002, 0, 0, 0));
    step(S, "start_0002", mk(16'h0002, 0, 1, 0));
    step(T, "tick_0001", mk(16'h0001, 0, 1, 0));
    step(T, "tick_done", mk(16'h0000, 0, 0, 1));
    step(N, "done_held", mk(16'h0000, 0, 0, 1));
    step(S, "done_start_ign", mk(16'h0000, 0, 0, 1));
    step(T, "alarm_tick1", mk(16'h0000, 0, 0, 1));
    step(T, "alarm_tick2", mk(16'h0000, 0, 0, 1));
    step(T, "alarm_clear", mk(16'h0000, 0, 0, 0));
    step(S, "start_at_zero", mk(16'h0000, 0, 0, 0));
    preset(0, 0, 1, 0);
    step(L, "load_0010", mk(16'h0010, 0, 0, 0));
    step(S, "start_0010", mk(16'h0010, 0, 1, 0));
    step(T, "tick_0009", mk(16'h0009, 0, 1, 0));
    step(P | T, "pause_tick", mk(16'h0009, 0, 0, 0));
    for (int i = 0; i < 5; i++) step(T, "paused_tick", mk(16'h0009, 0, 0, 0));
    step(S | T, "resume_tick_ign", mk(16'h0009, 0, 1, 0));
    step(T, "tick_0008", mk(16'h0008, 0, 1, 0));
    step(S | P, "start_pause_run", mk(16'h0008, 0, 0, 0));
    step(S | P, "start_pause_paused", mk(16'h0008, 0, 0, 0));
    preset(7, 7, 7, 12);
    step(L, "clamp_7759", mk(16'h7759, 0, 0, 0));
    preset(15, 10, 9, 9);
    step(L, "clamp_9959", mk(16'h9959, 0, 0, 0));
    step(T, "idle_tick_ign", mk(16'h9959, 0, 0, 0));
    preset(0, 0, 0, 0);
    step(L, "load_0000", mk(16'h0000, 0, 0, 0));
    step(S, "start_0000_ign", mk(16'h0000, 0, 0, 0));
    preset(1, 0, 0, 0);
    step(L, "load_1000", mk(16'h1000, 0, 0, 0));
    step(S, "start_1000", mk(16'h1000, 0, 1, 0));
    step(T, "tick_0959", mk(16'h0959, 1, 1, 0));
    reset = 1'b1;
    step(T, "reset_mid_run", mk(16'h0000, 0, 0, 0));
    reset = 1'b0;
    preset(0, 0, 2, 0);
    step(L, "load_0020", mk(16'h0020, 0, 0, 0));
    step(S, "start_0020", mk(16'h0020, 0, 1, 0));
    step(T, "tick_0019", mk(16'h0019, 0, 1, 0));
    preset(0, 5, 3, 0);
    step(L | T, "load_mid_run", mk(16'h0530, 0, 0, 0));
    step(T, "after_load_idle", mk(16'h0530, 0, 0, 0));
    preset(0, 0, 0, 1);
    step(L, "load_0001", mk(16'h0001, 0, 0, 0));
    step(S, "start_0001", mk(16'h0001, 0, 1, 0));
    step(T, "tick_done2", mk(16'h0000, 0, 0, 1));
    step(P, "done_pause_ign", mk(16'h0000, 0, 0, 1));
    step(A, "ack", mk(16'h0000, 0, 0, 0));
    step(S, "idle_after_ack", mk(16'h0000, 0, 0, 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
